disp_src_scan: RTL and testbench
================================

# disp_src_scan

Parametrised display-source selector for the seven-segment debug display, placed between the CPU/GPIO write path and the seven-segment scanner. It selects one of `NCH` 32-bit debug channels for display. Channel 0 is a CPU-written shadow register that captures every CPU write, so no write is lost while another channel is shown. An optional auto-scan mode rotates through all channels with a programmable dwell time. A freeze input holds the display, and status outputs flag display updates and unseen CPU writes.

## Interface
- `SELW`, 3, channel-select width; `NCH = 2**SELW` channels.
- `DW`, 32, data width of every channel and of `disp_num`.
- `DWELL`, 50_000_000, falling edges spent on each channel in auto mode; legal range 1..2**32-1.
- `RST_VAL`, 32'hAA5555AA, reset value of `disp_num` and of the CPU shadow register.
- `clk`  in  1  system clock; all state updates on the falling edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_we`  in  1  CPU write strobe for the display GPIO address.
- `cpu_data`  in  DW  CPU write data.
- `sel`  in  SELW  manual channel select (switches).
- `auto_en`  in  1  auto-scan enable.
- `freeze`  in  1  hold display and channel pointer.
- `test_data`  in  (NCH-1)*DW  packed channels 1..NCH-1; channel k occupies bits [k*DW-1 : (k-1)*DW].
- `disp_num`  out  DW  value to the seven-segment scanner (registered).
- `cur_ch`  out  SELW  channel currently driving `disp_num`.
- `upd`  out  1  one-cycle pulse: `disp_num` changed value on this edge.
- `cpu_dirty`  out  1  a CPU write occurred that has not yet been displayed.

## Operation
- Reset values: `disp_num = RST_VAL`, shadow register `= RST_VAL`, `cur_ch = 0`, dwell counter = 0, `upd = 0`, `cpu_dirty = 0`. Reset acts immediately, including in the middle of a dwell.
- Shadow register: loads `cpu_data` on every edge where `cpu_we = 1`, independent of `sel`, `auto_en` and `freeze`.
- Channel 0 source is the next-state value of the shadow register. A write is therefore displayed on the same edge it is captured when channel 0 is selected.
- Channel pointer `ch_next`:
  - `freeze = 1`: hold the current value.
  - Else `auto_en = 0`: `ch_next = sel`.
  - Else (auto mode): the dwell counter increments each edge. When it reaches `DWELL-1`, the counter clears and `cur_ch` advances by 1, wrapping from `NCH-1` to 0.
- Entering auto mode (`auto_en` 0→1 sampled, not frozen) clears the dwell counter and starts from the current `cur_ch`. Leaving auto mode returns `cur_ch` to `sel` on the next edge.
- `freeze = 1` also holds the dwell counter.
- `disp_num <= channel[ch_next]` unless `freeze = 1`, in which case it holds.
- `upd = 1` for one cycle when the value loaded into `disp_num` differs from its previous value; otherwise 0. Reloading an equal value does not pulse.
- `cpu_dirty`:
  - Set on `cpu_we` when `ch_next != 0` or `freeze = 1`.
  - Cleared on any non-frozen edge with `ch_next = 0`.
  - If both conditions occur on the same edge (write with `ch_next = 0`, not frozen), the result is clear.

## Timing
- All registers update on the falling edge of `clk`. CPU signals launched on the rising edge are therefore sampled at mid-cycle.
- Latency from a `sel`, `cpu_we` or `test_data` change to `disp_num`: one falling edge.
- Auto mode: each channel is displayed for exactly `DWELL` falling edges. With `DWELL = 1` the channel advances every edge.
- `upd` and `cpu_dirty` are registered and align with the `disp_num` update.
- `test_data` is assumed stable around the falling edge; the block provides no synchronisation.

## Configuration
- `DISP_AUTO_SCAN_EN` defined: auto-scan logic and the dwell counter are built as described above.
- Not defined: `auto_en` is ignored, there is no dwell counter, and `cur_ch` follows `sel` (subject to `freeze`). All other behaviour is unchanged.

## Test plan
Bench parameters: `SELW=2`, `DWELL=3`, macro defined.
- Reset, then one edge with `sel=0` and no writes → `disp_num = 32'hAA5555AA`, `cur_ch = 0`, `upd = 0`.
- `sel=2`, `test_data` channel 2 = 32'h12345678 → `disp_num = 32'h12345678` after one edge and `upd` pulses once. A CPU write of 32'hDEADBEEF on the next edge → `cpu_dirty = 1`. Then `sel=0` → `disp_num = 32'hDEADBEEF` and `cpu_dirty = 0`.
- `auto_en=1` starting at `cur_ch = 3` → `cur_ch` sequence is 3,3,3,0,0,0,1…, wrapping 3→0. Drop `auto_en` with `sel=1` → `cur_ch = 1` on the next edge.
- `freeze=1` in auto mode for 5 edges while the CPU writes 32'h0000CAFE → `disp_num` and `cur_ch` are held, `upd = 0`, `cpu_dirty = 1`. Release → the dwell count resumes from its held value.
- Assert `rst` asynchronously mid-dwell with `cur_ch = 2` → all outputs return to reset values immediately, without waiting for a clock edge.
- Rebuild without the macro, `auto_en=1`, `sel=3` → `cur_ch` stays 3 for 10 edges.

Source files
------------

// File: rtl/disp_src_scan.sv
// -----------------------------------------------------------------------------
// disp_src_scan
//
// Chooses which 32-bit debug channel drives the seven-segment scanner.
// Channel 0 is a shadow of the CPU display register. It captures every CPU
// write, so a write is not lost while another channel is on the display.
// Channels 1..NCH-1 come from the packed test_data bus. An optional auto-scan
// mode steps through all channels, dwelling DWELL edges on each one. freeze
// holds the display, the channel pointer and the dwell counter.
//
// All state changes on the FALLING edge of clk. CPU signals launched on the
// rising edge are therefore sampled at mid-cycle.
//
// Build option:
//   DISP_AUTO_SCAN_EN  defined    : auto-scan logic and dwell counter present
//                      undefined  : auto_en ignored, cur_ch follows sel
//
// Ports:
//   clk        in   system clock (falling-edge active)
//   rst        in   asynchronous, active-high reset
//   cpu_we     in   CPU write strobe for the display register
//   cpu_data   in   CPU write data
//   sel        in   manual channel select
//   auto_en    in   auto-scan enable
//   freeze     in   hold display, channel pointer and dwell counter
//   test_data  in   channels 1..NCH-1, channel k at [k*DW-1 -: DW]
//   disp_num   out  registered value to the seven-segment scanner
//   cur_ch     out  channel currently driving disp_num
//   upd        out  one-cycle pulse when disp_num changed value
//   cpu_dirty  out  a CPU write has not yet been displayed
// -----------------------------------------------------------------------------
module disp_src_scan #(
    parameter int unsigned   SELW    = 3,
    parameter int unsigned   DW      = 32,
    parameter int unsigned   DWELL   = 50_000_000,
    parameter logic [DW-1:0] RST_VAL = 32'hAA5555AA
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_we,
    input  logic [DW-1:0]            cpu_data,
    input  logic [SELW-1:0]          sel,
    input  logic                     auto_en,
    input  logic                     freeze,
    input  logic [(2**SELW-1)*DW-1:0] test_data,
    output logic [DW-1:0]            disp_num,
    output logic [SELW-1:0]          cur_ch,
    output logic                     upd,
    output logic                     cpu_dirty
);

    localparam int unsigned NCH        = 2**SELW;
    localparam logic [31:0] DWELL_LAST = 32'(DWELL - 1);

    logic [DW-1:0]   shadow;
    logic [DW-1:0]   shadow_next;
    logic [DW-1:0]   chan [NCH];
    logic [DW-1:0]   chan_val;
    logic [SELW-1:0] ch_next;

    // Channel 0 shows the value the shadow is about to hold, so a write is
    // displayed on the same edge that captures it.
    assign shadow_next = cpu_we ? cpu_data : shadow;

    always_comb begin
        chan[0] = shadow_next;
        for (int k = 1; k < NCH; k++) begin
            chan[k] = test_data[k*DW-1 -: DW];
        end
    end

    assign chan_val = chan[ch_next];

`ifdef DISP_AUTO_SCAN_EN
    logic [31:0] dwell_cnt;
    logic [31:0] cnt_next;
    logic        auto_q;     // auto_en as seen on the last non-frozen edge

    always_comb begin
        ch_next  = cur_ch;
        cnt_next = dwell_cnt;
        if (!freeze) begin
            if (auto_en) begin
                if (!auto_q) begin
                    // Entry edge: stay on the current channel and start a
                    // fresh dwell. This edge is the first of the dwell.
                    cnt_next = '0;
                end else if (dwell_cnt == DWELL_LAST) begin
                    cnt_next = '0;
                    ch_next  = cur_ch + 1'b1;  // wraps NCH-1 -> 0
                end else begin
                    cnt_next = dwell_cnt + 32'd1;
                end
            end else begin
                ch_next = sel;
            end
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt <= '0;
            auto_q    <= 1'b0;
        end else begin
            dwell_cnt <= cnt_next;
            if (!freeze) begin
                auto_q <= auto_en;
            end
        end
    end
`else
    logic        unused_auto;
    logic [31:0] unused_dwell;

    assign unused_auto  = auto_en;
    assign unused_dwell = DWELL_LAST;

    always_comb begin
        ch_next = freeze ? cur_ch : sel;
    end
`endif

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= RST_VAL;
            disp_num  <= RST_VAL;
            cur_ch    <= '0;
            upd       <= 1'b0;
            cpu_dirty <= 1'b0;
        end else begin
            shadow <= shadow_next;
            cur_ch <= ch_next;
            if (freeze) begin
                upd <= 1'b0;
            end else begin
                disp_num <= chan_val;
                upd      <= (chan_val != disp_num);
            end
            // A non-frozen edge that selects channel 0 has just displayed the
            // shadow, so it clears the flag even if a write lands on it.
            if (!freeze && ch_next == '0) begin
                cpu_dirty <= 1'b0;
            end else if (cpu_we) begin
                cpu_dirty <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_disp_src_scan.sv
module tb_disp_src_scan;
  localparam int          SELW  = 2;
  localparam int          DW    = 32;
  localparam int          DWELL = 3;
  localparam int          NCH   = 4;
  localparam logic [31:0] RV    = 32'hAA5555AA;
`ifdef DISP_AUTO_SCAN_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_data = '0;
  logic [1:0]  sel = '0;
  logic        auto_en = 1'b0;
  logic        freeze = 1'b0;
  logic [31:0] tchan [1:3];
  logic [95:0] test_data;
  logic [31:0] disp_num;
  logic [1:0]  cur_ch;
  logic        upd;
  logic        cpu_dirty;

  assign test_data = {tchan[3], tchan[2], tchan[1]};

  disp_src_scan #(.SELW(SELW), .DW(DW), .DWELL(DWELL), .RST_VAL(RV)) dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_data(cpu_data), .sel(sel),
    .auto_en(auto_en), .freeze(freeze), .test_data(test_data),
    .disp_num(disp_num), .cur_ch(cur_ch), .upd(upd), .cpu_dirty(cpu_dirty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] disp;
    logic [1:0]  ch;
    logic        upd;
    logic        dirty;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state: what the display shows, the CPU shadow, and
  // how many edges the current channel has been on screen in auto mode.
  logic [31:0] m_disp;
  logic [31:0] m_shadow;
  int          m_ch;
  int          m_spent;
  bit          m_auto;
  bit          m_dirty;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_disp   = RV;
    m_shadow = RV;
    m_ch     = 0;
    m_spent  = 0;
    m_auto   = 1'b0;
    m_dirty  = 1'b0;
  endtask

  // Predict the outcome of the coming falling edge from the current inputs.
  task automatic model_edge();
    logic [31:0] shadow_n;
    logic [31:0] val;
    int          nx;
    bit          changed;
    exp_t        e;
    shadow_n = cpu_we ? cpu_data : m_shadow;
    if (freeze) begin
      nx = m_ch;
    end else if (auto_en && AUTO) begin
      if (!m_auto) begin
        nx = m_ch;
        m_spent = 1;
      end else if (m_spent == DWELL) begin
        nx = (m_ch + 1) % NCH;
        m_spent = 1;
      end else begin
        nx = m_ch;
        m_spent = m_spent + 1;
      end
    end else begin
      nx = int'(sel);
    end
    if (!freeze) m_auto = auto_en && AUTO;
    val = (nx == 0) ? shadow_n : tchan[nx];
    changed = 1'b0;
    if (!freeze) begin
      changed = (val != m_disp);
      m_disp  = val;
    end
    if (!freeze && nx == 0) m_dirty = 1'b0;
    else if (cpu_we)        m_dirty = 1'b1;
    m_shadow = shadow_n;
    m_ch     = nx;
    e.disp   = m_disp;
    e.ch     = 2'(m_ch);
    e.upd    = changed;
    e.dirty  = m_dirty;
    sbq.push_back(e);
  endtask

  // Inputs are changed only between cycles; each call covers one falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #2;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 2))
      0:       return 32'h0;
      1:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      check("disp_num", disp_num, mon_e.disp);
      check("cur_ch", 32'(cur_ch), 32'(mon_e.ch));
      check("upd", 32'(upd), 32'(mon_e.upd));
      check("cpu_dirty", 32'(cpu_dirty), 32'(mon_e.dirty));
    end
  end

  initial begin
    logic [31:0] d0;
    logic [1:0]  c0;
    int          seq [7];
    int          guard;
    seq = '{3, 3, 3, 0, 0, 0, 1};
    for (int k = 1; k < NCH; k++) tchan[k] = $urandom;

    // Reset and the first quiet edge
    #1 rst = 1'b1;
    #1;
    check("rst_disp", disp_num, RV);
    check("rst_ch", 32'(cur_ch), 32'd0);
    check("rst_upd", 32'(upd), 32'd0);
    check("rst_dirty", 32'(cpu_dirty), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    sel = 2'd0;
    cyc();
    check("first_disp", disp_num, RV);

    // Manual select, a hidden CPU write, then show channel 0
    tchan[2] = 32'h12345678;
    sel = 2'd2;
    cyc();
    check("sel2_disp", disp_num, 32'h12345678);
    check("sel2_upd", 32'(upd), 32'd1);
    cpu_we = 1'b1;
    cpu_data = 32'hDEADBEEF;
    cyc();
    cpu_we = 1'b0;
    check("hidden_dirty", 32'(cpu_dirty), 32'd1);
    sel = 2'd0;
    cyc();
    check("ch0_disp", disp_num, 32'hDEADBEEF);
    check("ch0_dirty", 32'(cpu_dirty), 32'd0);

    // Auto-scan sequence from channel 3
    sel = 2'd3;
    cyc();
`ifdef DISP_AUTO_SCAN_EN
    auto_en = 1'b1;
    sel = 2'd1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      check("auto_seq", 32'(cur_ch), 32'(seq[i]));
    end
    auto_en = 1'b0;
    cyc();
    check("auto_exit", 32'(cur_ch), 32'd1);
`else
    auto_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("no_auto_hold", 32'(cur_ch), 32'(seq[0]));
    end
    auto_en = 1'b0;
    cyc();
`endif

    // Freeze in auto mode while the CPU keeps writing
    auto_en = 1'b1;
    sel = 2'd2;
    cyc();
    cyc();
    d0 = disp_num;
    c0 = cur_ch;
    freeze = 1'b1;
    cpu_we = 1'b1;
    cpu_data = 32'h0000CAFE;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("frz_disp", disp_num, d0);
      check("frz_ch", 32'(cur_ch), 32'(c0));
      check("frz_upd", 32'(upd), 32'd0);
      check("frz_dirty", 32'(cpu_dirty), 32'd1);
    end
    freeze = 1'b0;
    cpu_we = 1'b0;
    repeat (8) cyc();

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      sel = 2'($urandom);
      cpu_we = ($urandom_range(0, 3) == 0);
      cpu_data = pick();
      freeze = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
      for (int k = 1; k < NCH; k++) begin
        if ($urandom_range(0, 3) == 0) tchan[k] = pick();
      end
      cyc();
    end

    // Asynchronous reset in the middle of a dwell on channel 2
    freeze = 1'b0;
    cpu_we = 1'b0;
    auto_en = 1'b1;
    sel = 2'd2;
    guard = 0;
    while (!(m_ch == 2 && (!AUTO || m_spent == 2)) && guard < 40) begin
      cyc();
      guard++;
    end
    check("reach_ch2", 32'(cur_ch), 32'd2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_disp", disp_num, RV);
    check("arst_ch", 32'(cur_ch), 32'd0);
    check("arst_upd", 32'(upd), 32'd0);
    check("arst_dirty", 32'(cpu_dirty), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      sel = 2'($urandom);
      cpu_we = ($urandom_range(0, 2) == 0);
      cpu_data = pick();
      cyc();
    end

    guard = 0;
    while (sbq.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
